// File: rtl/byte_queue.sv
// Receive-side byte FIFO behind the deserializer.
// Intake handshake FSM acks each byte once; consumer pops on request.
module byte_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk_100mhz,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       data_ready_in,
  output logic                       ack_out,
  input  logic                       dequeue_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       valid_out,
  output logic [$clog2(DEPTH):0]     len_out,
  output logic                       full_out,
  output logic                       empty_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LEN_FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACK      = 2'd1;
  localparam logic [1:0] WAIT_LOW = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_d;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      len;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full  = (len == LEN_FULL);
  assign empty = (len == '0);
  assign push  = (state == IDLE) && data_ready_in && !full;
  assign pop   = dequeue_in && !empty;

  assign ack_out   = (state == ACK);
  assign len_out   = len;
  assign full_out  = full;
  assign empty_out = empty;

  // Intake FSM next state: one ack per byte, then wait for ready to drop.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:     if (push) state_d = ACK;
      ACK:      state_d = WAIT_LOW;
      WAIT_LOW: if (!data_ready_in) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM state and write pointer.
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      state  <= IDLE;
      wr_ptr <= '0;
    end else begin
      state <= state_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Storage array; contents survive reset and are don't-care after it.
  always_ff @(posedge clk_100mhz) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // Pop side: registered output byte plus a one-cycle valid strobe.
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      rd_ptr    <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (pop) begin
      data_out  <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1'b1;
      valid_out <= 1'b1;
    end else begin
      valid_out <= 1'b0;
    end
  end

  // Occupancy counter; push and pop together leave it unchanged.
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      len <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   len <= len + 1'b1;
        2'b01:   len <= len - 1'b1;
        default: len <= len;
      endcase
    end
  end

endmodule
